// File: rtl/systolic_skew_feeder.sv
// Skew feeder for the 4x4 systolic multiplier.
// Buffers A rows / B columns and emits the diagonal wavefront.
module systolic_skew_feeder #(
    parameter int DW           = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [4*DW-1:0] ld_a_row,
    input  logic [4*DW-1:0] ld_b_col,
    output logic [DW-1:0] a1,
    output logic [DW-1:0] a2,
    output logic [DW-1:0] a3,
    output logic [DW-1:0] a4,
    output logic [DW-1:0] b1,
    output logic [DW-1:0] b2,
    output logic [DW-1:0] b3,
    output logic [DW-1:0] b4,
    output logic          acc_clr,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int SMAX = (DRAIN_CYCLES > 7) ? DRAIN_CYCLES : 7;
    localparam int SW   = $clog2(SMAX);
    localparam logic [SW-1:0] STEP_LAST  = SW'(6);
    localparam logic [SW-1:0] DRAIN_LAST =
        SW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [SW-1:0]   step_q, step_d;
    logic [4*DW-1:0] a_buf_q [4];
    logic [4*DW-1:0] a_buf_d [4];
    logic [4*DW-1:0] b_buf_q [4];
    logic [4*DW-1:0] b_buf_d [4];
    logic [DW-1:0]   a_q [4];
    logic [DW-1:0]   a_d [4];
    logic [DW-1:0]   b_q [4];
    logic [DW-1:0]   b_d [4];
    logic            accept;

    assign accept = ld_valid && ld_ready;

    // State, counters, buffers and registered streams.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                a_buf_q[i] <= '0;
                b_buf_q[i] <= '0;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            for (int i = 0; i < 4; i++) begin
                a_buf_q[i] <= a_buf_d[i];
                b_buf_q[i] <= b_buf_d[i];
                a_q[i]     <= a_d[i];
                b_q[i]     <= b_d[i];
            end
        end
    end

    // Next state: load beats in IDLE, then step through the job phases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_buf_d[cnt_q] = ld_a_row;
                    b_buf_d[cnt_q] = ld_b_col;
                    cnt_d          = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                step_d  = '0;
            end
            S_STREAM: begin
                if (step_q == STEP_LAST) begin
                    step_d  = '0;
                    state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_DRAIN: begin
                if (step_q == DRAIN_LAST) begin
                    step_d  = '0;
                    state_d = S_DONE;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Skewed vector for the upcoming stream step: lane k lags by k.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            a_d[k] = '0;
            b_d[k] = '0;
        end
        if (state_d == S_STREAM) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) begin
                    if (int'(step_d) == k + j) begin
                        a_d[k] = a_buf_q[k][DW*j +: DW];
                        b_d[k] = b_buf_q[k][DW*j +: DW];
                    end
                end
            end
        end
    end

    // Status and handshake outputs decoded from the current state.
    always_comb begin
        ld_ready = (state_q == S_IDLE) && reset;
        acc_clr  = (state_q == S_CLEAR);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
    end

    assign a1 = a_q[0];
    assign a2 = a_q[1];
    assign a3 = a_q[2];
    assign a4 = a_q[3];
    assign b1 = b_q[0];
    assign b2 = b_q[1];
    assign b3 = b_q[2];
    assign b4 = b_q[3];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder.
// Hand-computed wavefronts for reference and all-ones jobs.
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_a_row = '0;
    logic [31:0] ld_b_col = '0;
    logic [7:0]  a1, a2, a3, a4, b1, b2, b3, b4;
    logic        acc_clr, busy, done;
    logic [63:0] strm;

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [127:0] REF_A = {32'h09080600, 32'h07030208,
                                      32'h03040805, 32'h05090107};
    localparam logic [127:0] REF_B = {32'h06050801, 32'h04010803,
                                      32'h00020600, 32'h01060205};
    localparam logic [127:0] FF_AB = {128{1'b1}};

    systolic_skew_feeder #(.DW(8), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_a_row(ld_a_row), .ld_b_col(ld_b_col),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .acc_clr(acc_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign strm = {a1, a2, a3, a4, b1, b2, b3, b4};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // id 0 = reference job, id 1 = all elements 255
    function automatic logic [63:0] exp_vec(input int id, input int t);
        logic [63:0] v;
        v = '0;
        if (id == 0) begin
            case (t)
                0: v = 64'h07000000_05000000;
                1: v = 64'h01050000_02000000;
                2: v = 64'h09080800_06060300;
                3: v = 64'h05040200_01020801;
                4: v = 64'h00030306_00000108;
                5: v = 64'h00000708_00000405;
                6: v = 64'h00000009_00000006;
                default: v = '0;
            endcase
        end else begin
            case (t)
                0: v = 64'hFF000000_FF000000;
                1: v = 64'hFFFF0000_FFFF0000;
                2: v = 64'hFFFFFF00_FFFFFF00;
                3: v = 64'hFFFFFFFF_FFFFFFFF;
                4: v = 64'h00FFFFFF_00FFFFFF;
                5: v = 64'h0000FFFF_0000FFFF;
                6: v = 64'h000000FF_000000FF;
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Entered just after a negedge in IDLE; returns at the CLEAR negedge.
    task automatic load_job(input logic [127:0] av, input logic [127:0] bv,
                            input int gap);
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b0;
            repeat (gap) @(negedge clk);
            ld_valid = 1'b1;
            ld_a_row = av[32*i +: 32];
            ld_b_col = bv[32*i +: 32];
            @(negedge clk);
        end
        ld_valid = 1'b0;
    endtask

    // Checks CLEAR, the 7 stream steps, drain and done; abort_at stops early.
    task automatic run_stream(input int id, input bit garbage,
                              input int abort_at);
        chk("clr_pulse", 64'(acc_clr), 64'd1);
        chk("clr_busy", 64'(busy), 64'd1);
        chk("clr_ready", 64'(ld_ready), 64'd0);
        chk("clr_zero", strm, 64'd0);
        if (garbage) begin
            ld_valid = 1'b1;
            ld_a_row = 32'hDEADBEEF;
            ld_b_col = 32'hA5A5C3C3;
        end
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            chk($sformatf("job%0d_t%0d", id, t), strm, exp_vec(id, t));
            chk($sformatf("clr_low_t%0d", t), 64'(acc_clr), 64'd0);
            if (t == abort_at) return;
        end
        for (int d = 0; d < 3; d++) begin
            @(negedge clk);
            chk($sformatf("drain%0d", d), strm, 64'd0);
            chk($sformatf("drain_done%0d", d), 64'(done), 64'd0);
        end
        @(negedge clk);
        chk("done_hi", 64'(done), 64'd1);
        chk("done_ready", 64'(ld_ready), 64'd0);
        chk("done_zero", strm, 64'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        chk("done_lo", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready", 64'(ld_ready), 64'd1);
    endtask

    initial begin
        reset    = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_a_row = $urandom;
            ld_b_col = $urandom;
            @(negedge clk);
            chk("rst_strm", strm, 64'd0);
            chk("rst_ready", 64'(ld_ready), 64'd0);
            chk("rst_flags", {61'd0, acc_clr, busy, done}, 64'd0);
        end
        ld_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rel_ready", 64'(ld_ready), 64'd1);
        chk("rel_busy", 64'(busy), 64'd0);
        @(negedge clk);

        load_job(REF_A, REF_B, 0);
        run_stream(0, 1'b0, -1);

        load_job(REF_A, REF_B, 2);
        run_stream(0, 1'b1, -1);

        load_job(REF_A, REF_B, 0);
        run_stream(0, 1'b0, 3);
        reset = 1'b0;
        #1;
        chk("abort_strm", strm, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_clr", 64'(acc_clr), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_ready", 64'(ld_ready), 64'd1);

        ld_valid = 1'b1;
        ld_a_row = 32'hFFFFFFFF;
        ld_b_col = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        load_job(REF_A, REF_B, 1);
        run_stream(0, 1'b0, -1);

        load_job(FF_AB, FF_AB, 0);
        run_stream(1, 1'b0, -1);
        load_job(REF_A, REF_B, 0);
        run_stream(0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
